// File: rtl/data_mem_responder.sv
// -----------------------------------------------------------------------------
// data_mem_responder
//
// Responder end of the CPU data-memory interface. It accepts one load/store
// request at a time over a valid/ready handshake, waits a configurable number
// of cycles, performs the access on a word-organised store with byte enables,
// and then holds a response until the requester takes it.
//
// Handshake rule (both channels): a transfer happens on the rising clk edge
// where valid && ready are both high. A source that raises valid keeps its
// payload stable until that edge.
//
// Ports:
//   clk        system clock, all state on the rising edge
//   rst        asynchronous, active-high reset (storage contents survive it)
//   req_valid  request present
//   req_ready  high only while idle; the request is captured on accept
//   req_we     1 = store, 0 = load
//   req_addr   byte address; word index is req_addr[31:2]
//   req_wdata  store data
//   req_be     store byte enables (bit i -> bits 8i+7:8i), ignored for loads
//   resp_valid response present, held until resp_ready
//   resp_ready requester accepts the response
//   resp_rdata load data; 0 for stores and errors
//   resp_err   address misaligned or beyond DEPTH_WORDS
//
// The FSM state is kept in the signal "state" (type state_t) so checkers can
// bind to it directly.
// -----------------------------------------------------------------------------
module data_mem_responder #(
    parameter int DEPTH_WORDS = 64,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_be,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);

    localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_EXEC = 2'd2,
        S_RESP = 2'd3
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [3:0]  wait_cnt;
    logic        cap_we;
    logic [31:0] cap_addr;
    logic [31:0] cap_wdata;
    logic [3:0]  cap_be;

    logic [31:0] mem [DEPTH_WORDS];

    logic          accept;
    logic          acc_err;
    logic [AW-1:0] acc_idx;

    assign accept  = req_valid && req_ready;
    assign acc_err = (cap_addr[1:0] != 2'b00) ||
                     (cap_addr[31:2] >= 30'(DEPTH_WORDS));
    assign acc_idx = cap_addr[AW+1:2];

    // Next-state and handshake outputs.
    always_comb begin
        state_nxt  = state;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        case (state)
            S_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) state_nxt = S_WAIT;
            end
            S_WAIT: begin
                if (wait_cnt == 4'd0) state_nxt = S_EXEC;
            end
            S_EXEC: begin
                state_nxt = S_RESP;
            end
            S_RESP: begin
                resp_valid = 1'b1;
                if (resp_ready) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // The counter is loaded with the full WAIT_CYCLES on accept, so the WAIT
    // state always lasts WAIT_CYCLES+1 cycles (the first of those is the
    // request-register cycle). Together with the single EXEC cycle this puts
    // resp_valid high WAIT_CYCLES+2 edges after the accept edge, including
    // the zero-wait configuration.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            wait_cnt   <= 4'd0;
            cap_we     <= 1'b0;
            cap_addr   <= 32'd0;
            cap_wdata  <= 32'd0;
            cap_be     <= 4'd0;
            resp_rdata <= 32'd0;
            resp_err   <= 1'b0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                cap_we    <= req_we;
                cap_addr  <= req_addr;
                cap_wdata <= req_wdata;
                cap_be    <= req_be;
                wait_cnt  <= 4'(WAIT_CYCLES);
            end else if (state == S_WAIT && wait_cnt != 4'd0) begin
                wait_cnt <= wait_cnt - 4'd1;
            end
            if (state == S_EXEC) begin
                resp_err   <= acc_err;
                resp_rdata <= (acc_err || cap_we) ? 32'd0 : mem[acc_idx];
            end
        end
    end

    // Storage is deliberately outside the reset domain. A reset that arrives
    // before the edge ending EXEC forces state to IDLE, so no write happens.
    always_ff @(posedge clk) begin
        if (state == S_EXEC && cap_we && !acc_err) begin
            for (int i = 0; i < 4; i++) begin
                if (cap_be[i]) mem[acc_idx][8*i +: 8] <= cap_wdata[8*i +: 8];
            end
        end
    end

endmodule

// File: tb/tb_data_mem_responder.sv
module tb_data_mem_responder;

  // ---------------------------------------------------------------------------
  // Clock / reset. Instance 0 uses 2 wait states, instance 1 uses none.
  // ---------------------------------------------------------------------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        req_valid  [2];
  logic        req_ready  [2];
  logic        req_we     [2];
  logic [31:0] req_addr   [2];
  logic [31:0] req_wdata  [2];
  logic [3:0]  req_be     [2];
  logic        resp_valid [2];
  logic        resp_ready [2];
  logic [31:0] resp_rdata [2];
  logic        resp_err   [2];

  data_mem_responder #(.DEPTH_WORDS(64), .WAIT_CYCLES(2)) u_dut_w2 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_we(req_we[0]),
    .req_addr(req_addr[0]), .req_wdata(req_wdata[0]), .req_be(req_be[0]),
    .resp_valid(resp_valid[0]), .resp_ready(resp_ready[0]),
    .resp_rdata(resp_rdata[0]), .resp_err(resp_err[0])
  );

  data_mem_responder #(.DEPTH_WORDS(64), .WAIT_CYCLES(0)) u_dut_w0 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_we(req_we[1]),
    .req_addr(req_addr[1]), .req_wdata(req_wdata[1]), .req_be(req_be[1]),
    .resp_valid(resp_valid[1]), .resp_ready(resp_ready[1]),
    .resp_rdata(resp_rdata[1]), .resp_err(resp_err[1])
  );

  // ---------------------------------------------------------------------------
  // Scoreboard: reference memory per instance and an expected-response queue
  // holding {err, rdata}.
  // ---------------------------------------------------------------------------
  logic [31:0] ref_mem [2][64];
  logic [32:0] exp_q[$];
  int n_total = 0;
  int n_pass  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
  endtask

  function automatic int latency(input int d);
    return (d == 0) ? 4 : 2;
  endfunction

  // Reference behaviour of one access, applied at accept time.
  function automatic logic [32:0] model_access(input int d, input logic we,
      input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] be);
    logic [31:0] a;
    int idx;
    a = addr;
    if (a[1:0] != 2'b00 || (a >> 2) >= 64) return {1'b1, 32'd0};
    idx = int'(a >> 2);
    if (we) begin
      for (int i = 0; i < 4; i++)
        if (be[i]) ref_mem[d][idx][8*i +: 8] = wdata[8*i +: 8];
      return {1'b0, 32'd0};
    end
    return {1'b0, ref_mem[d][idx]};
  endfunction

  // ---------------------------------------------------------------------------
  // Driver: one full transaction with optional response backpressure.
  // stall == 0 holds resp_ready high from the accept onward.
  // ---------------------------------------------------------------------------
  task automatic do_txn(input int d, input logic we, input logic [31:0] addr,
      input logic [31:0] wdata, input logic [3:0] be, input int stall);
    logic [32:0] exp;
    int k;
    @(negedge clk);
    req_valid[d] = 1'b1; req_we[d] = we; req_addr[d] = addr;
    req_wdata[d] = wdata; req_be[d] = be;
    resp_ready[d] = (stall == 0);
    k = 0;
    while (!req_ready[d] && k < 50) begin @(negedge clk); k++; end
    if (!req_ready[d]) begin
      check("accept_timeout", 32'(req_ready[d]), 32'd1);
      req_valid[d] = 1'b0;
      return;
    end
    @(posedge clk);
    exp = model_access(d, we, addr, wdata, be);
    exp_q.push_back(exp);
    #1;
    // Later changes to the request inputs must not affect this transaction.
    req_valid[d] = 1'b0; req_we[d] = $urandom_range(0, 1);
    req_addr[d] = $urandom; req_wdata[d] = $urandom; req_be[d] = 4'($urandom);
    k = 0;
    while (!resp_valid[d] && k < 40) begin @(posedge clk); #1; k++; end
    check("latency", 32'(k), 32'(latency(d)));
    exp = exp_q.pop_front();
    check("rdata", resp_rdata[d], exp[31:0]);
    check("err", 32'(resp_err[d]), 32'(exp[32]));
    for (int s = 0; s < stall; s++) begin
      @(posedge clk); #1;
      check("hold_valid", 32'(resp_valid[d]), 32'd1);
      check("hold_rdata", resp_rdata[d], exp[31:0]);
      check("hold_err", 32'(resp_err[d]), 32'(exp[32]));
      check("hold_req_ready", 32'(req_ready[d]), 32'd0);
    end
    resp_ready[d] = 1'b1;
    @(posedge clk); #1;
    check("ready_after_resp", 32'(req_ready[d]), 32'd1);
    check("valid_after_resp", 32'(resp_valid[d]), 32'd0);
    resp_ready[d] = 1'b0;
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    int a0, a1, v0, v1, cyc;
    logic [31:0] addr;
    logic acc;

    for (int d = 0; d < 2; d++) begin
      req_valid[d] = 1'b0; req_we[d] = 1'b0; req_addr[d] = '0;
      req_wdata[d] = '0; req_be[d] = '0; resp_ready[d] = 1'b0;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      check("rst_req_ready", 32'(req_ready[d]), 32'd1);
      check("rst_resp_valid", 32'(resp_valid[d]), 32'd0);
      check("rst_rdata", resp_rdata[d], 32'd0);
      check("rst_err", 32'(resp_err[d]), 32'd0);
    end
    @(negedge clk); rst = 1'b0;

    // Store/load round trip and byte-enable merge.
    do_txn(0, 1'b1, 32'h8, 32'hDEADBEEF, 4'b1111, 0);
    do_txn(0, 1'b0, 32'h8, 32'h0, 4'b0000, 0);
    do_txn(0, 1'b1, 32'h8, 32'h11223344, 4'b0101, 0);
    do_txn(0, 1'b0, 32'h8, 32'h0, 4'b0000, 0);
    check("be_merge_ref", ref_mem[0][2], 32'hDE22BE44);

    // Fill the rest of instance 0 with known data.
    for (int i = 0; i < 64; i++)
      if (i != 2) do_txn(0, 1'b1, 32'(i * 4), $urandom, 4'b1111, 0);

    // Error responses, then confirm word 0 was untouched.
    do_txn(0, 1'b0, 32'h6, 32'h0, 4'b0000, 0);
    do_txn(0, 1'b1, 32'h100, 32'hFFFFFFFF, 4'b1111, 0);
    do_txn(0, 1'b1, 32'h2, 32'hFFFFFFFF, 4'b1111, 0);
    do_txn(0, 1'b0, 32'h0, 32'h0, 4'b0000, 0);
    do_txn(0, 1'b0, 32'hFC, 32'h0, 4'b0000, 0);
    do_txn(0, 1'b1, 32'h4, 32'h0, 4'b0000, 0);
    do_txn(0, 1'b0, 32'h4, 32'h0, 4'b0000, 0);

    // Response backpressure for 5 cycles.
    do_txn(0, 1'b0, 32'h8, 32'h0, 4'b0000, 5);

    // Randomized mix including misaligned and out-of-range addresses.
    for (int t = 0; t < 40; t++) begin
      case ($urandom_range(0, 5))
        0:       addr = 32'($urandom_range(0, 255)) * 4 + 32'($urandom_range(1, 3));
        1:       addr = 32'($urandom_range(64, 4095)) * 4;
        default: addr = 32'($urandom_range(0, 63)) * 4;
      endcase
      do_txn(0, 1'($urandom_range(0, 1)), addr, $urandom, 4'($urandom),
             $urandom_range(0, 3));
    end

    // Reset during WAIT discards a captured store.
    @(negedge clk);
    req_valid[0] = 1'b1; req_we[0] = 1'b1; req_addr[0] = 32'hC;
    req_wdata[0] = 32'hCAFEF00D; req_be[0] = 4'b1111;
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    #1;
    check("midrst_req_ready", 32'(req_ready[0]), 32'd1);
    check("midrst_resp_valid", 32'(resp_valid[0]), 32'd0);
    check("midrst_rdata", resp_rdata[0], 32'd0);
    check("midrst_err", 32'(resp_err[0]), 32'd0);
    do_txn(0, 1'b0, 32'hC, 32'h0, 4'b0000, 0);

    // Zero wait states: seed words 0 and 1, then back-to-back loads with
    // req_valid held high.
    do_txn(1, 1'b1, 32'h0, 32'h13579BDF, 4'b1111, 0);
    do_txn(1, 1'b1, 32'h4, 32'h2468ACE0, 4'b1111, 0);
    @(negedge clk);
    req_valid[1] = 1'b1; req_we[1] = 1'b0; req_addr[1] = 32'h0; req_be[1] = 4'b0000;
    resp_ready[1] = 1'b1;
    a0 = -1; a1 = -1; v0 = -1; v1 = -1;
    for (cyc = 1; cyc <= 20 && v1 < 0; cyc++) begin
      acc = req_ready[1];
      @(posedge clk);
      if (acc) begin
        if (a0 < 0) begin a0 = cyc; #1; req_addr[1] = 32'h4; end
        else begin a1 = cyc; #1; req_valid[1] = 1'b0; end
      end else #1;
      if (resp_valid[1]) begin
        if (v0 < 0) begin
          v0 = cyc;
          check("w0_rdata0", resp_rdata[1], ref_mem[1][0]);
        end else begin
          v1 = cyc;
          check("w0_rdata1", resp_rdata[1], ref_mem[1][1]);
        end
      end
      @(negedge clk);
    end
    req_valid[1] = 1'b0; resp_ready[1] = 1'b0;
    check("w0_latency0", 32'(v0 - a0), 32'd2);
    check("w0_accept_gap", 32'(a1 - a0), 32'd4);
    check("w0_latency1", 32'(v1 - a1), 32'd2);

    repeat (2) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not complete, %0d/%0d checks passed",
             n_pass, n_total);
    $fatal(1, "watchdog expired");
  end

endmodule
